// File: rtl/rggen_axi4lite_pkg.sv
// Shared encodings for the pipelined AXI4-Lite to rggen register-bus adapter.
package rggen_axi4lite_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ  = 2'b10,
    RGGEN_WRITE = 2'b11
  } rggen_access_e;

  localparam int ARB_WRITE_FIRST = 0;
  localparam int ARB_READ_FIRST  = 1;
  localparam int ARB_ROUND_ROBIN = 2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_WRITE,
    ST_WAIT_READ
  } arb_state_e;

endpackage

// File: rtl/rggen_axi4lite_pipelined_adapter_response_fifo.sv
// Response queue for the adapter's B and R channels.
// The head reads as zero while the queue is empty.
module rggen_response_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Payload storage needs no reset: the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/rggen_axi4lite_pipelined_adapter.sv
// AXI4-Lite slave to rggen register bus with independent B/R response queues.
// Optional macro RGGEN_AXI4LITE_PROT_CHECK_EN rejects non-secure (prot[1]) requests.
module rggen_axi4lite_pipelined_adapter
  import rggen_axi4lite_pkg::*;
#(
  parameter int                     ID_WIDTH            = 0,
  parameter int                     ADDRESS_WIDTH       = 8,
  parameter int                     LOCAL_ADDRESS_WIDTH = 8,
  parameter int                     BUS_WIDTH           = 32,
  parameter int                     REGISTERS           = 1,
  parameter bit                     PRE_DECODE          = 0,
  parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
  parameter int                     BYTE_SIZE           = 256,
  parameter bit                     ERROR_STATUS        = 0,
  parameter bit [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0,
  parameter int                     ARBITRATION         = 0,
  parameter int                     RESPONSE_DEPTH      = 2
)(
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_awvalid,
  output logic                                     o_awready,
  input  logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] i_awid,
  input  logic [ADDRESS_WIDTH-1:0]                 i_awaddr,
  input  logic [2:0]                               i_awprot,
  input  logic                                     i_wvalid,
  output logic                                     o_wready,
  input  logic [BUS_WIDTH-1:0]                     i_wdata,
  input  logic [BUS_WIDTH/8-1:0]                   i_wstrb,
  output logic                                     o_bvalid,
  input  logic                                     i_bready,
  output logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] o_bid,
  output logic [1:0]                               o_bresp,
  input  logic                                     i_arvalid,
  output logic                                     o_arready,
  input  logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] i_arid,
  input  logic [ADDRESS_WIDTH-1:0]                 i_araddr,
  input  logic [2:0]                               i_arprot,
  output logic                                     o_rvalid,
  input  logic                                     i_rready,
  output logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] o_rid,
  output logic [1:0]                               o_rresp,
  output logic [BUS_WIDTH-1:0]                     o_rdata,
  output logic                                     o_register_valid,
  output logic [1:0]                               o_register_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0]           o_register_address,
  output logic [BUS_WIDTH-1:0]                     o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]                   o_register_strobe,
  input  logic [REGISTERS-1:0]                     i_register_active,
  input  logic [REGISTERS-1:0]                     i_register_ready,
  input  logic [2*REGISTERS-1:0]                   i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0]           i_register_read_data
);
  localparam int IDW = (ID_WIDTH > 0) ? ID_WIDTH : 1;
  localparam int BW  = IDW + 2;
  localparam int RW  = IDW + 2 + BUS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] RANGE_LO = {1'b0, BASE_ADDRESS};
  localparam logic [ADDRESS_WIDTH:0] RANGE_HI = RANGE_LO + (ADDRESS_WIDTH + 1)'(BYTE_SIZE);

  arb_state_e                r_state, w_next_state;
  logic                      r_last_write;
  logic                      w_b_full, w_b_empty, w_r_full, w_r_empty;
  logic                      w_wr_cand, w_rd_cand, w_grant_wr, w_grant_rd;
  logic                      w_issue_wr, w_issue_rd, w_issue, w_done;
  logic                      w_in_range, w_mapped, w_reject, w_forward;
  logic [ADDRESS_WIDTH-1:0]  w_addr;
  logic                      w_hit_ready;
  logic [1:0]                w_hit_status, w_status;
  logic [BUS_WIDTH-1:0]      w_hit_data, w_rdata;
  logic [BW-1:0]             w_b_head;
  logic [RW-1:0]             w_r_head;

  // "Full" is the registered count; a same-cycle pop never frees a slot.
  assign w_wr_cand = i_awvalid && i_wvalid && !w_b_full;
  assign w_rd_cand = i_arvalid && !w_r_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_issue_wr && !w_done)      w_next_state = ST_WAIT_WRITE;
        else if (w_issue_rd && !w_done) w_next_state = ST_WAIT_READ;
      end
      default: if (w_done) w_next_state = ST_IDLE;
    endcase
  end

  // Grant: held on a stalled access, otherwise arbitrated afresh each cycle.
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    unique case (r_state)
      ST_WAIT_WRITE: w_grant_wr = 1'b1;
      ST_WAIT_READ:  w_grant_rd = 1'b1;
      default: begin
        if (w_wr_cand && w_rd_cand) begin
          if (ARBITRATION == ARB_READ_FIRST)       w_grant_rd = 1'b1;
          else if (ARBITRATION == ARB_ROUND_ROBIN) begin
            w_grant_rd = r_last_write;
            w_grant_wr = !r_last_write;
          end else                                 w_grant_wr = 1'b1;
        end else begin
          w_grant_wr = w_wr_cand;
          w_grant_rd = w_rd_cand;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_last_write <= 1'b0;
    else if (w_done) r_last_write <= w_issue_wr;
  end

  assign w_issue_wr = w_grant_wr && w_wr_cand;
  assign w_issue_rd = w_grant_rd && w_rd_cand;
  assign w_issue    = w_issue_wr || w_issue_rd;
  assign w_addr     = w_issue_wr ? i_awaddr : i_araddr;
  assign w_in_range = !PRE_DECODE || (({1'b0, w_addr} >= RANGE_LO) && ({1'b0, w_addr} < RANGE_HI));
  assign w_mapped   = |i_register_active;

`ifdef RGGEN_AXI4LITE_PROT_CHECK_EN
  assign w_reject = w_issue_wr ? i_awprot[1] : i_arprot[1];
`else
  assign w_reject = 1'b0;
`endif
  logic w_unused_prot;
  assign w_unused_prot = ^{i_awprot, i_arprot};

  assign w_forward             = w_issue && w_in_range && !w_reject;
  assign o_register_valid      = w_forward;
  assign o_register_access     = w_issue_wr ? RGGEN_WRITE : RGGEN_READ;
  assign o_register_address    = LOCAL_ADDRESS_WIDTH'(w_addr);
  assign o_register_write_data = i_wdata;
  assign o_register_strobe     = w_issue_wr ? i_wstrb : '1;

  // Register mux: only the active register that is ready contributes.
  always_comb begin
    w_hit_ready  = 1'b0;
    w_hit_status = '0;
    w_hit_data   = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (i_register_active[i] && i_register_ready[i]) begin
        w_hit_ready  = 1'b1;
        w_hit_status = w_hit_status | i_register_status[2*i +: 2];
        w_hit_data   = w_hit_data | i_register_read_data[BUS_WIDTH*i +: BUS_WIDTH];
      end
    end
  end

  // Rejected or unmapped accesses complete immediately without a register ack.
  always_comb begin
    w_done   = 1'b0;
    w_status = OKAY;
    w_rdata  = DEFAULT_READ_DATA;
    if (w_reject) begin
      w_done   = 1'b1;
      w_status = SLVERR;
    end else if (!w_in_range || !w_mapped) begin
      w_done   = 1'b1;
      w_status = ERROR_STATUS ? SLVERR : OKAY;
    end else begin
      w_done   = w_hit_ready;
      w_status = w_hit_status;
      w_rdata  = w_hit_data;
    end
    w_done = w_done && w_issue;
  end

  assign o_awready = w_done && w_issue_wr;
  assign o_wready  = w_done && w_issue_wr;
  assign o_arready = w_done && w_issue_rd;

  rggen_response_fifo #(.WIDTH(BW), .DEPTH(RESPONSE_DEPTH)) u_b_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (o_awready),
    .i_data  ({i_awid, w_status}),
    .i_pop   (i_bready),
    .o_full  (w_b_full),
    .o_empty (w_b_empty),
    .o_head  (w_b_head)
  );

  rggen_response_fifo #(.WIDTH(RW), .DEPTH(RESPONSE_DEPTH)) u_r_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (o_arready),
    .i_data  ({i_arid, w_status, w_rdata}),
    .i_pop   (i_rready),
    .o_full  (w_r_full),
    .o_empty (w_r_empty),
    .o_head  (w_r_head)
  );

  assign o_bvalid = !w_b_empty;
  assign o_bid    = w_b_head[BW-1 -: IDW];
  assign o_bresp  = w_b_head[1:0];
  assign o_rvalid = !w_r_empty;
  assign o_rid    = w_r_head[RW-1 -: IDW];
  assign o_rresp  = w_r_head[BUS_WIDTH +: 2];
  assign o_rdata  = w_r_head[BUS_WIDTH-1:0];

endmodule
